// File: rtl/poly_music_processor.sv
// Polyphonic square-wave sequencer: plays a register-file sequence of steps,
// each holding a duration in milliseconds and one half-period per voice, and
// mixes the voices into a single speaker bit with a first-order sigma-delta.
module poly_music_processor #(
   parameter int N_VOICES = 2,
   parameter int DEPTH    = 16,
   parameter int PW       = 12,
   localparam int AW      = $clog2(DEPTH),
   localparam int DW      = 8 + N_VOICES * PW,
   localparam int ACCW    = $clog2(N_VOICES + 1) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         ticks_per_milli,
   input  logic                start,
   input  logic                stop,
   input  logic                loop_en,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [DW-1:0]       wr_data,
   output logic [N_VOICES-1:0] voice,
   output logic                sound,
   output logic [7:0]          led
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   // Sequence storage; deliberately outside the reset domain so a reset
   // does not lose the programmed tune.
   logic [DW-1:0]   mem [DEPTH];

   logic [1:0]      state;
   logic [1:0]      nxt_state;
   logic [AW-1:0]   step_idx;
   logic [AW-1:0]   nxt_addr;
   logic [AW-1:0]   load_addr;
   logic            do_load;
   logic            start_go;
   logic            step_end;
   logic            ms_tick;
   logic            is_last;
   logic [7:0]      cur_dur;
   logic [7:0]      ms_cnt;
   logic [7:0]      nxt_dur;
   logic [7:0]      first_dur;
   logic [15:0]     presc;
   logic [15:0]     t_last;
   logic [PW-1:0]   cur_half [N_VOICES];
   logic [PW-1:0]   vcnt     [N_VOICES];
   logic [DW-1:0]   ld_entry;
   logic [ACCW-1:0] acc;
   logic [ACCW-1:0] pop;
   logic [ACCW-1:0] acc_sum;

   // Sequence memory write port, usable in every state.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Millisecond tick, end-of-step detection and look-ahead at the next entry.
   // A zero ticks_per_milli behaves as one; ">=" keeps the prescaler bounded
   // if the rate is lowered while it is mid-count.
   always_comb begin
      t_last    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
      ms_tick   = (presc >= t_last);
      step_end  = ms_tick && (({1'b0, ms_cnt} + 9'd1) == {1'b0, cur_dur});
      nxt_addr  = step_idx + AW'(1);
      is_last   = (step_idx == LAST_IDX);
      nxt_dur   = mem[nxt_addr][DW-1 -: 8];
      first_dur = mem[0][DW-1 -: 8];
      start_go  = start && !stop;
   end

   // Next-state and step-load decision; a zero-duration entry is a
   // terminator and is never loaded.
   always_comb begin
      nxt_state = state;
      do_load   = 1'b0;
      load_addr = '0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_go) begin
               if (first_dur != 8'd0) begin
                  nxt_state = S_PLAY;
                  do_load   = 1'b1;
               end else begin
                  nxt_state = S_DONE;
               end
            end
         end
         S_PLAY: begin
            if (stop) begin
               nxt_state = S_IDLE;
            end else if (step_end) begin
               if (!is_last && (nxt_dur != 8'd0)) begin
                  do_load   = 1'b1;
                  load_addr = nxt_addr;
               end else if (loop_en && (first_dur != 8'd0)) begin
                  do_load   = 1'b1;
               end else begin
                  nxt_state = S_DONE;
               end
            end
         end
         default: nxt_state = S_IDLE;
      endcase
      ld_entry = mem[load_addr];
   end

   // State, step registers, prescaler, ms counter and voice generators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         step_idx <= '0;
         cur_dur  <= '0;
         presc    <= '0;
         ms_cnt   <= '0;
         voice    <= '0;
         for (int v = 0; v < N_VOICES; v++) begin
            cur_half[v] <= '0;
            vcnt[v]     <= '0;
         end
      end else begin
         state <= nxt_state;
         if (do_load) begin
            step_idx <= load_addr;
            cur_dur  <= ld_entry[DW-1 -: 8];
            presc    <= '0;
            ms_cnt   <= '0;
            voice    <= '0;
            for (int v = 0; v < N_VOICES; v++) begin
               cur_half[v] <= ld_entry[v*PW +: PW];
               vcnt[v]     <= '0;
            end
         end else if (nxt_state == S_PLAY) begin
            presc <= ms_tick ? 16'd0 : presc + 16'd1;
            if (ms_tick) ms_cnt <= ms_cnt + 8'd1;
            for (int v = 0; v < N_VOICES; v++) begin
               if (cur_half[v] == '0) begin
                  voice[v] <= 1'b0;
                  vcnt[v]  <= '0;
               end else if (vcnt[v] >= cur_half[v] - PW'(1)) begin
                  voice[v] <= ~voice[v];
                  vcnt[v]  <= '0;
               end else begin
                  vcnt[v]  <= vcnt[v] + PW'(1);
               end
            end
         end else begin
            presc  <= '0;
            ms_cnt <= '0;
            voice  <= '0;
            for (int v = 0; v < N_VOICES; v++) vcnt[v] <= '0;
            // DONE keeps the last index; IDLE and an empty-sequence start show 0.
            if ((nxt_state == S_IDLE) || ((state != S_PLAY) && start_go))
               step_idx <= '0;
         end
      end
   end

   // Number of voices currently high, added into the sigma-delta accumulator.
   always_comb begin
      pop = '0;
      for (int v = 0; v < N_VOICES; v++) pop = pop + ACCW'(voice[v]);
      acc_sum = acc + pop;
   end

   // Sigma-delta mixer; silent and cleared whenever playback is not continuing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         sound <= 1'b0;
      end else if ((state == S_PLAY) && (nxt_state == S_PLAY)) begin
         if (acc_sum >= ACCW'(N_VOICES)) begin
            sound <= 1'b1;
            acc   <= acc_sum - ACCW'(N_VOICES);
         end else begin
            sound <= 1'b0;
            acc   <= acc_sum;
         end
      end else begin
         acc   <= '0;
         sound <= 1'b0;
      end
   end

   // Status LEDs: step index, done and busy flags.
   always_comb begin
      led             = 8'd0;
      led[AW-1:0]     = step_idx;
      led[6]          = (state == S_DONE);
      led[7]          = (state == S_PLAY);
   end

endmodule

// File: tb/tb_poly_music_processor.sv
// Directed bench for poly_music_processor (N_VOICES=2, DEPTH=16, PW=12).
// A step-level model (step start, cycles elapsed, arithmetic voice phase)
// is checked against the DUT every cycle, alongside hand-computed literals.
module tb_poly_music_processor;

   logic        clk;
   logic        rst;
   logic [15:0] ticks_per_milli;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  voice;
   logic        sound;
   logic [7:0]  led;

   int total = 0;
   int bad   = 0;

   // Model state: 0 idle, 1 play, 2 done.
   int          m_state, m_idx, m_k, m_dur, m_acc;
   int          m_h [2];
   logic        m_sound;
   logic [31:0] m_mem [16];

   poly_music_processor #(.N_VOICES(2), .DEPTH(16), .PW(12)) dut (
      .clk             (clk),
      .rst             (rst),
      .ticks_per_milli (ticks_per_milli),
      .start           (start),
      .stop            (stop),
      .loop_en         (loop_en),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .voice           (voice),
      .sound           (sound),
      .led             (led)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ent(int dur, int h0, int h1);
      return {8'(dur), 12'(h1), 12'(h0)};
   endfunction

   function automatic int dur_of(logic [31:0] e);
      return int'(e[31:24]);
   endfunction

   function automatic logic exp_voice_bit(int v);
      if (m_state != 1 || m_h[v] == 0) return 1'b0;
      return ((m_k / m_h[v]) % 2) == 1;
   endfunction

   function automatic logic [1:0] exp_voice();
      return {exp_voice_bit(1), exp_voice_bit(0)};
   endfunction

   function automatic logic [7:0] exp_led();
      logic [7:0] r;
      r    = 8'(m_idx & 15);
      r[7] = (m_state == 1);
      r[6] = (m_state == 2);
      return r;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_idx   = 0;
      m_k     = 0;
      m_acc   = 0;
      m_sound = 1'b0;
   endtask

   // Compare DUT to model, then advance the model across the coming edge.
   task automatic model_cycle();
      int         teff, nstate, load, pop;
      logic [1:0] ev;
      if (rst) model_reset();
      ev = exp_voice();
      check("cyc_voice", 32'(voice), 32'(ev));
      check("cyc_sound", 32'(sound), 32'(m_sound));
      check("cyc_led", 32'(led), 32'(exp_led()));
      if (!rst) begin
         teff   = (ticks_per_milli == 16'd0) ? 1 : int'(ticks_per_milli);
         nstate = m_state;
         load   = -1;
         pop    = int'(ev[0]) + int'(ev[1]);
         if (m_state != 1) begin
            if (start && !stop) begin
               if (dur_of(m_mem[0]) != 0) begin
                  nstate = 1;
                  load   = 0;
               end else begin
                  nstate = 2;
                  m_idx  = 0;
               end
            end
         end else if (stop) begin
            nstate = 0;
            m_idx  = 0;
         end else if (m_k + 1 == m_dur * teff) begin
            if (m_idx != 15 && dur_of(m_mem[m_idx + 1]) != 0) load = m_idx + 1;
            else if (loop_en && dur_of(m_mem[0]) != 0) load = 0;
            else nstate = 2;
         end
         if (m_state == 1 && nstate == 1) begin
            m_acc = m_acc + pop;
            if (m_acc >= 2) begin
               m_sound = 1'b1;
               m_acc   = m_acc - 2;
            end else begin
               m_sound = 1'b0;
            end
         end else begin
            m_acc   = 0;
            m_sound = 1'b0;
         end
         if (load >= 0) begin
            m_idx  = load;
            m_dur  = dur_of(m_mem[load]);
            m_h[0] = int'(m_mem[load][11:0]);
            m_h[1] = int'(m_mem[load][23:12]);
            m_k    = 0;
         end else if (nstate == 1) begin
            m_k++;
         end
         m_state = nstate;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
   endtask

   // One clock: check/advance at the falling edge, return 1ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int addr, logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = 4'(addr);
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   logic [7:0] v0_pat;
   int         sc, vc;

   initial begin
      v0_pat          = 8'b0011_1000;
      rst             = 1'b1;
      ticks_per_milli = 16'd4;
      start           = 1'b0;
      stop            = 1'b0;
      loop_en         = 1'b0;
      wr_en           = 1'b0;
      wr_addr         = '0;
      wr_data         = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_h[0] = 0;
      m_h[1] = 0;
      m_dur  = 0;
      model_reset();

      // Reset state
      tick();
      tick();
      check("rst_led", 32'(led), 32'h0);
      check("rst_voice", 32'(voice), 32'h0);
      check("rst_sound", 32'(sound), 32'h0);
      rst = 1'b0;
      tick();

      // Single step: voice0 H=3, voice1 rest, 2 ms at 4 ticks/ms
      wr(0, ent(2, 3, 0));
      wr(1, ent(0, 0, 0));
      pulse_start();
      check("play_led", 32'(led), 32'h80);
      check("model_led_play", 32'(exp_led()), 32'h80);
      for (int k = 1; k < 8; k++) begin
         tick();
         check("v0_phase", 32'(voice[0]), 32'(v0_pat[k]));
         check("v1_rest", 32'(voice[1]), 32'h0);
      end
      tick();
      check("done_led", 32'(led), 32'h40);
      check("model_led_done", 32'(exp_led()), 32'h40);
      check("done_voice", 32'(voice), 32'h0);
      check("done_sound", 32'(sound), 32'h0);

      // Looping: stays busy on entry 0; stop returns to idle
      loop_en = 1'b1;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         tick();
         check("loop_led", 32'(led), 32'h80);
      end
      pulse_stop();
      check("stop_led", 32'(led), 32'h0);
      check("stop_voice", 32'(voice), 32'h0);
      check("stop_sound", 32'(sound), 32'h0);
      loop_en = 1'b0;

      // Both voices H=1: 00/11 alternation, sound lags one cycle
      wr(0, ent(2, 1, 1));
      pulse_start();
      tick();
      check("dual_v_k1", 32'(voice), 32'h3);
      check("dual_s_k1", 32'(sound), 32'h0);
      tick();
      check("dual_v_k2", 32'(voice), 32'h0);
      check("dual_s_k2", 32'(sound), 32'h1);
      tick();
      check("dual_v_k3", 32'(voice), 32'h3);
      check("dual_s_k3", 32'(sound), 32'h0);
      for (int i = 0; i < 5; i++) tick();
      check("dual_done", 32'(led), 32'h40);

      // One voice of two at 50% duty gives sound at half its density
      wr(0, ent(2, 1, 0));
      loop_en = 1'b1;
      pulse_start();
      sc = 0;
      vc = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         sc += int'(sound);
         vc += int'(voice[0]);
      end
      check("duty_sound", 32'(sc), 32'd4);
      check("duty_voice", 32'(vc), 32'd8);
      pulse_stop();
      loop_en = 1'b0;

      // Full memory, 1 ms steps at 1 tick/ms: index walks 0..15 then DONE
      for (int i = 0; i < 16; i++) wr(i, ent(1, i + 1, 15 - i));
      ticks_per_milli = 16'd0;
      pulse_start();
      check("walk_0", 32'(led), 32'h80);
      for (int i = 1; i < 16; i++) begin
         tick();
         check("walk_idx", 32'(led), 32'(8'h80 | 8'(i)));
      end
      tick();
      check("walk_done", 32'(led), 32'h4f);

      // Async reset from DONE, then start+stop together stays idle
      rst = 1'b1;
      #1;
      check("async_rst_led", 32'(led), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      ticks_per_milli = 16'd4;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_led", 32'(led), 32'h0);
      tick();
      check("start_stop_led2", 32'(led), 32'h0);

      // Reset mid-step, memory retained, replay matches first run
      wr(0, ent(2, 3, 0));
      wr(1, ent(0, 0, 0));
      pulse_start();
      for (int i = 0; i < 4; i++) tick();
      check("mid_v0", 32'(voice[0]), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_voice", 32'(voice), 32'h0);
      check("mid_rst_led", 32'(led), 32'h0);
      check("mid_rst_sound", 32'(sound), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("no_auto_replay", 32'(led), 32'h0);
      pulse_start();
      check("replay_led", 32'(led), 32'h80);
      for (int k = 1; k < 8; k++) begin
         tick();
         check("replay_v0", 32'(voice[0]), 32'(v0_pat[k]));
      end
      tick();
      check("replay_done", 32'(led), 32'h40);

      // Overwrite the playing entry: heard only on the next loop pass
      loop_en = 1'b1;
      pulse_start();
      tick();
      wr(0, ent(2, 2, 0));
      check("ovr_cur_v0", 32'(voice[0]), 32'h0);
      for (int i = 0; i < 8; i++) tick();
      check("ovr_next_v0", 32'(voice[0]), 32'h1);
      check("ovr_next_led", 32'(led), 32'h80);
      pulse_stop();
      check("ovr_stop_led", 32'(led), 32'h0);
      loop_en = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
